// File: rtl/chess_pkg.sv
// chess_pkg: shared definitions for the move-generation blocks.
//   - piece type codes and the colour bit position inside a board code
//   - move-word field offsets and a helper that packs a move word
//   - the 6-bit square-index type and the scan FSM state encoding
package chess_pkg;

  typedef logic [5:0] sq_idx_t;
  typedef logic [2:0] ptype_t;

  localparam ptype_t PT_EMPTY  = 3'd0;
  localparam ptype_t PT_PAWN   = 3'd1;
  localparam ptype_t PT_KNIGHT = 3'd2;
  localparam ptype_t PT_BISHOP = 3'd3;
  localparam ptype_t PT_ROOK   = 3'd4;
  localparam ptype_t PT_QUEEN  = 3'd5;
  localparam ptype_t PT_KING   = 3'd6;

  // Colour bit inside a stored piece code ([2:0] type, [3] colour).
  localparam int COLOR_BIT = 3;

  localparam int MV_FROM_LSB  = 26;
  localparam int MV_TO_LSB    = 20;
  localparam int MV_MOVER_LSB = 17;
  localparam int MV_CAPT_LSB  = 14;
  localparam int MV_CAP_BIT   = 13;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SRC    = 3'd1,
    ST_WALK_W = 3'd2,
    ST_WALK_E = 3'd3,
    ST_DONE   = 3'd4
  } scan_state_e;

  // Packs a move word; bits [12:0] are always zero.
  function automatic logic [31:0] pack_move(input sq_idx_t from_sq, input sq_idx_t to_sq,
                                            input ptype_t mover, input ptype_t capt,
                                            input logic cap);
    logic [31:0] w;
    w = 32'd0;
    w[MV_FROM_LSB +: 6]  = from_sq;
    w[MV_TO_LSB +: 6]    = to_sq;
    w[MV_MOVER_LSB +: 3] = mover;
    w[MV_CAPT_LSB +: 3]  = capt;
    w[MV_CAP_BIT]        = cap;
    return w;
  endfunction

endpackage

// File: rtl/move_fifo.sv
// move_fifo: synchronous first-word fall-through FIFO.
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_en_i, wr_data_i  : write request; accepted when not full, or when a
//                         read fires in the same cycle
//   rd_en_i             : pop the head entry (ignored while empty)
//   rd_data_o           : head entry, zero while empty
//   full_o, empty_o     : occupancy flags
module move_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_fire_s;
  logic             rd_fire_s;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == (AW+1)'(0));
  assign rd_fire_s = rd_en_i && !empty_o;
  // A simultaneous pop makes room for a write into a full FIFO.
  assign wr_fire_s = wr_en_i && (!full_o || rd_fire_s);
  assign rd_data_o = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // Storage array, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (wr_fire_s) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (rd_fire_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({wr_fire_s, rd_fire_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rank_slide_gen.sv
// rank_slide_gen: single-rank horizontal move generator.
// Walks west then east rays of engine-colour rooks, queens (sliding) and
// kings (one step), pushing one move word per cycle into move_fifo.
//   clk, clear_n              : clock, asynchronous active-low reset
//   engine_color              : side to move, latched on accepted start
//   load, load_idx, load_piece: board write, IDLE only
//   start                     : begin a scan, IDLE only
//   busy, done                : scan in progress / one-cycle DONE pulse
//   move_valid/ready/data     : FIFO output handshake and move word
//   move_count                : moves pushed since start, saturating at 63
module rank_slide_gen
  import chess_pkg::*;
#(
  parameter int N_SQUARES  = 8,
  parameter int RANK_BASE  = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        engine_color,
  input  logic        load,
  input  logic [2:0]  load_idx,
  input  logic [5:0]  load_piece,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        move_valid,
  input  logic        move_ready,
  output logic [31:0] move_data,
  output logic [5:0]  move_count
);

  localparam logic [2:0] LAST_P = 3'(N_SQUARES - 1);
  localparam logic [3:0] N_SQ4  = 4'(N_SQUARES);

  scan_state_e state_q, state_d;
  logic [3:0]  board_q [8];
  logic [2:0]  p_q, p_d;
  // t is one bit wider than p so that p-1 from 0 wraps to a value >= N.
  logic [3:0]  t_q, t_d;
  logic        color_q, color_d;
  logic [5:0]  count_q, count_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic [3:0]  src_piece_s, tgt_piece_s;
  ptype_t      src_type_s, tgt_type_s;
  logic        src_is_mover_s, tgt_in_range_s;
  logic        push_req_s, push_s, can_push_s, walk_term_s, walk_step_s;
  logic        fifo_full_s, fifo_empty_s, pop_s;
  logic [31:0] move_word_s;
  logic        unused_s;

  function automatic sq_idx_t pos_to_sq(input logic [2:0] pos);
    return sq_idx_t'(RANK_BASE + N_SQUARES - 1 - int'(pos));
  endfunction

  assign unused_s       = ^load_piece[5:4];
  assign src_piece_s    = board_q[p_q];
  assign src_type_s     = src_piece_s[2:0];
  assign tgt_in_range_s = (t_q < N_SQ4);
  assign tgt_piece_s    = tgt_in_range_s ? board_q[t_q[2:0]] : 4'd0;
  assign tgt_type_s     = tgt_piece_s[2:0];
  assign src_is_mover_s = (src_piece_s[COLOR_BIT] == color_q) &&
                          ((src_type_s == PT_ROOK) || (src_type_s == PT_QUEEN) ||
                           (src_type_s == PT_KING));
  assign pop_s          = !fifo_empty_s && move_ready;
  assign can_push_s     = !fifo_full_s || pop_s;
  assign push_s         = push_req_s && can_push_s;
  assign move_word_s    = pack_move(pos_to_sq(p_q), pos_to_sq(t_q[2:0]), src_type_s,
                                    tgt_type_s, (tgt_type_s != PT_EMPTY));

  // Ray-step decision: whether this target needs a push, ends the ray or advances.
  // A stalled push leaves both term and step low so the walker holds.
  always_comb begin
    push_req_s  = 1'b0;
    walk_term_s = 1'b0;
    walk_step_s = 1'b0;
    if ((state_q == ST_WALK_W) || (state_q == ST_WALK_E)) begin
      if (!tgt_in_range_s) begin
        walk_term_s = 1'b1;
      end else if (tgt_type_s == PT_EMPTY) begin
        push_req_s = 1'b1;
        if (can_push_s) begin
          walk_term_s = (src_type_s == PT_KING);
          walk_step_s = (src_type_s != PT_KING);
        end else begin
          walk_term_s = 1'b0;
        end
      end else if (tgt_piece_s[COLOR_BIT] == color_q) begin
        walk_term_s = 1'b1;
      end else begin
        push_req_s  = 1'b1;
        walk_term_s = can_push_s;
      end
    end else begin
      push_req_s = 1'b0;
    end
  end

  // Next-state and scan datapath (p, t, colour, move count).
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    t_d     = t_q;
    color_d = color_q;
    count_d = (push_s && (count_q != 6'd63)) ? (count_q + 6'd1) : count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SRC;
          p_d     = 3'd0;
          t_d     = 4'd0;
          color_d = engine_color;
          count_d = 6'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SRC: begin
        if (src_is_mover_s) begin
          t_d     = {1'b0, p_q} - 4'd1;
          state_d = ST_WALK_W;
        end else if (p_q == LAST_P) begin
          state_d = ST_DONE;
        end else begin
          p_d = p_q + 3'd1;
        end
      end
      ST_WALK_W: begin
        if (walk_term_s) begin
          state_d = ST_WALK_E;
          t_d     = {1'b0, p_q} + 4'd1;
        end else if (walk_step_s) begin
          t_d = t_q - 4'd1;
        end else begin
          t_d = t_q;
        end
      end
      ST_WALK_E: begin
        if (walk_term_s) begin
          if (p_q == LAST_P) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SRC;
            p_d     = p_q + 3'd1;
          end
        end else if (walk_step_s) begin
          t_d = t_q + 4'd1;
        end else begin
          t_d = t_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so busy/done come straight from flops.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // FSM state, scan datapath and registered status outputs.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      p_q     <= 3'd0;
      t_q     <= 4'd0;
      color_q <= 1'b0;
      count_q <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      t_q     <= t_d;
      color_q <= color_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Board register array; writable only while idle.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < 8; i++) begin
        board_q[i] <= 4'd0;
      end
    end else if ((state_q == ST_IDLE) && load && ({1'b0, load_idx} < N_SQ4)) begin
      board_q[load_idx] <= load_piece[3:0];
    end
  end

  move_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk       (clk),
    .rst_n     (clear_n),
    .wr_en_i   (push_s),
    .wr_data_i (move_word_s),
    .rd_en_i   (move_ready),
    .rd_data_o (move_data),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s)
  );

  assign move_valid = !fifo_empty_s;
  assign busy       = busy_q;
  assign done       = done_q;
  assign move_count = count_q;

endmodule

// File: tb/tb_rank_slide_gen.sv
// Bench for rank_slide_gen (N_SQUARES=8, RANK_BASE=0, FIFO_DEPTH=4).
// A ray-walking model builds the expected move list and busy length from
// the board contents; a scoreboard process checks every popped move word.
module tb_rank_slide_gen;

  localparam int N = 8;

  logic        clk;
  logic        clear_n;
  logic        engine_color;
  logic        load;
  logic [2:0]  load_idx;
  logic [5:0]  load_piece;
  logic        start;
  logic        busy;
  logic        done;
  logic        move_valid;
  logic        move_ready;
  logic [31:0] move_data;
  logic [5:0]  move_count;

  rank_slide_gen #(.N_SQUARES(N), .RANK_BASE(0), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .clear_n      (clear_n),
    .engine_color (engine_color),
    .load         (load),
    .load_idx     (load_idx),
    .load_piece   (load_piece),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .move_valid   (move_valid),
    .move_ready   (move_ready),
    .move_data    (move_data),
    .move_count   (move_count)
  );

  always #5 clk = ~clk;

  logic [3:0]  bm [N];
  logic [31:0] exp_q [$];
  int          model_w;
  int          errs = 0;
  int          checks = 0;
  bit          check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mw(input int p, input int t, input int mover,
                                     input int capt, input bit cap);
    logic [5:0] f;
    logic [5:0] to;
    f  = 6'(N - 1 - p);
    to = 6'(N - 1 - t);
    return {f, to, 3'(mover), 3'(capt), cap, 13'd0};
  endfunction

  // Expected moves and evaluated-target count from the rules of the rays.
  function automatic void build_model(input bit c);
    int typ;
    int t;
    exp_q.delete();
    model_w = 0;
    for (int p = 0; p < N; p++) begin
      typ = int'(bm[p][2:0]);
      if (bm[p][3] == c && (typ == 4 || typ == 5 || typ == 6)) begin
        for (int d = -1; d <= 1; d += 2) begin
          t = p + d;
          while (1) begin
            model_w++;
            if (t < 0 || t >= N) break;
            if (bm[t][2:0] == 3'd0) begin
              exp_q.push_back(mw(p, t, typ, 0, 1'b0));
              if (typ == 6) break;
              t += d;
            end else if (bm[t][3] == c) begin
              break;
            end else begin
              exp_q.push_back(mw(p, t, typ, int'(bm[t][2:0]), 1'b1));
              break;
            end
          end
        end
      end
    end
  endfunction

  // Scoreboard: every word the consumer takes must be the next expected one.
  always @(negedge clk) begin
    if (check_en && move_valid && move_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL extra_move: got %0h expected no further move", move_data);
      end else begin
        chk("move_word", move_data, exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 clear_n = 1'b0;
    @(posedge clk); #1 clear_n = 1'b1;
    for (int i = 0; i < N; i++) bm[i] = 4'd0;
  endtask

  task automatic load_sq(input int idx, input logic [5:0] code);
    @(posedge clk); #1;
    load = 1'b1; load_idx = 3'(idx); load_piece = code;
    @(posedge clk); #1 load = 1'b0;
    bm[idx] = code[3:0];
  endtask

  task automatic run_scan(input bit c, input int hand_busy, input int hand_moves,
                          input bit inject, input bit stall);
    int exp_busy, n_exp, cyc, dn, guard;
    build_model(c);
    exp_busy = N + model_w + 1;
    if (hand_busy >= 0) chk("model_busy_pin", exp_busy, hand_busy);
    chk("model_moves_pin", exp_q.size(), hand_moves);
    n_exp = exp_q.size();
    check_en = 1'b1;
    @(posedge clk); #1;
    move_ready = !stall; engine_color = c; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    cyc = 0; dn = 0; guard = 0;
    while (busy && guard < 3000) begin
      cyc++;
      if (done) dn++;
      if (inject && cyc == 3) begin
        start = 1'b1; load = 1'b1; load_idx = 3'd3; load_piece = 6'b000100;
      end
      if (inject && cyc == 4) begin
        start = 1'b0; load = 1'b0;
      end
      if (stall && cyc == 40) begin
        chk("stall_count", 32'(move_count), 32'd4);
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_valid", 32'(move_valid), 32'd1);
        @(posedge clk); #1 move_ready = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) begin
      checks++; errs++;
      $display("FAIL busy_timeout: busy still %0b after %0d cycles, required 0", busy, guard);
    end
    if (!stall) chk("busy_len", cyc, exp_busy);
    chk("done_pulses", dn, 1);
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(negedge clk);
    chk("move_count", 32'(move_count), n_exp);
    chk("valid_after_drain", 32'(move_valid), 32'd0);
    check_en = 1'b0;
  endtask

  initial begin
    int cyc;
    clk = 1'b0; clear_n = 1'b0; engine_color = 1'b0; load = 1'b0;
    load_idx = 3'd0; load_piece = 6'd0; start = 1'b0; move_ready = 1'b1;
    for (int i = 0; i < N; i++) bm[i] = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(move_valid), 32'd0);
    chk("rst_data", move_data, 32'd0);
    chk("rst_count", 32'(move_count), 32'd0);
    @(posedge clk); #1 clear_n = 1'b1;

    // White rook at west end on an empty rank; upper code bits are junk.
    load_sq(0, 6'b111100);
    build_model(1'b1);
    chk("model_rook_first", exp_q[0], {6'd7, 6'd6, 3'd4, 3'd0, 1'b0, 13'd0});
    run_scan(1'b1, 18, 7, 1'b0, 1'b0);
    // Same scan with start/load pulsed mid-scan, then again to see the board intact.
    run_scan(1'b1, 18, 7, 1'b1, 1'b0);
    run_scan(1'b1, 18, 7, 1'b0, 1'b0);

    // Queen with enemy pawn west and own knight east.
    do_reset();
    load_sq(4, 6'b001101);
    load_sq(2, 6'b000001);
    load_sq(6, 6'b001010);
    build_model(1'b1);
    chk("model_queen_cap", exp_q[1], {6'd3, 6'd5, 3'd5, 3'd1, 1'b1, 13'd0});
    chk("model_queen_east", exp_q[2], {6'd3, 6'd2, 3'd5, 3'd0, 1'b0, 13'd0});
    run_scan(1'b1, 13, 3, 1'b0, 1'b0);

    // King capturing an adjacent enemy rook, then the same board for black.
    do_reset();
    load_sq(0, 6'b001110);
    load_sq(1, 6'b000100);
    build_model(1'b1);
    chk("model_king_cap", exp_q[0], {6'd7, 6'd6, 3'd6, 3'd4, 1'b1, 13'd0});
    run_scan(1'b1, 11, 1, 1'b0, 1'b0);
    run_scan(1'b0, 17, 7, 1'b0, 1'b0);

    // Full FIFO stall with the consumer held off.
    do_reset();
    load_sq(0, 6'b001100);
    run_scan(1'b1, -1, 7, 1'b0, 1'b1);

    // Reset in the middle of a scan, then a start right after release.
    @(posedge clk); #1 engine_color = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 clear_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_valid", 32'(move_valid), 32'd0);
    chk("midrst_data", move_data, 32'd0);
    chk("midrst_count", 32'(move_count), 32'd0);
    for (int i = 0; i < N; i++) bm[i] = 4'd0;
    @(posedge clk); #1 clear_n = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("post_rst_start", 32'(busy), 32'd1);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("empty_busy_len", cyc, N + 1);
    chk("empty_count", 32'(move_count), 32'd0);
    chk("empty_valid", 32'(move_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
